uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the 8N1 UART link; it is the send-side counterpart of the oversampling UART receiver. It accepts a byte over a valid/ready handshake and shifts it out as one start bit, eight data bits (MSB first), and one stop bit. Each bit lasts exactly `Oversample` clock cycles, so a receiver running from the same clock with the same `Oversample` decodes the byte unchanged. Back-to-back frames go out with no idle gap.

## Interface
- `Oversample`, default 16: clock cycles per bit. Must be ≥ 4 and the same value as the receiver's.
- `clk`  input  1: single clock. All state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `data`  input  8: byte to send. Sampled only on a handshake cycle.
- `valid`  input  1: upstream has a byte on `data`.
- `ready`  output  1: transmitter accepts `data` this cycle. A transfer happens when `valid && ready` at a rising edge.
- `out`  output  1: serial line, registered. Idle level is 1.
- `busy`  output  1: a frame is in progress (START, DATA or STOP).
- `done`  output  1: one-cycle pulse in the final cycle of a stop bit.

## Operation
- States:
  - IDLE: `out` = 1.
  - START: `out` = 0.
  - DATA: `out` = `shiftReg[7]`.
  - STOP: `out` = 1.
- Registers:
  - `sampleCount`, width $clog2(Oversample), loads `Oversample-1` and counts down.
  - `bitCount`, 4 bits.
  - `shiftReg`, 8 bits.
- IDLE, handshake (`valid && ready`):
  - `shiftReg` ← `data`, `sampleCount` ← `Oversample-1`, state → START.
  - Without a handshake, stay in IDLE.
- Bit ends: every non-IDLE state holds for `sampleCount` from `Oversample-1` down to 0. The cycle with `sampleCount == 0` is the bit's last cycle.
- START, last cycle → DATA, with `bitCount` ← 7.
- DATA, last cycle:
  - If `bitCount == 0` → STOP.
  - Otherwise `shiftReg` ← `{shiftReg[6:0], 1'b0}`, `bitCount` decrements, stay in DATA.
- STOP, last cycle:
  - `done` = 1 and `ready` = 1.
  - On a handshake, reload `shiftReg` and go straight to START (back-to-back).
  - Otherwise → IDLE.
- Output definitions:
  - `ready` = (state == IDLE) || (state == STOP && `sampleCount == 0`).
  - `busy` = (state != IDLE).
  - `done` = (state == STOP && `sampleCount == 0`).
- `valid` while `ready` = 0 is ignored. Upstream holds `valid`/`data` until accepted. Changes to `data` after acceptance have no effect on the frame in flight.
- Reset:
  - State → IDLE, `out` → 1, `sampleCount` → `Oversample-1`, `bitCount` → 7, `shiftReg` → 0.
  - Reset asserted mid-frame aborts the frame. `out` is 1 from the next cycle, and the byte in flight is dropped with no `done`.
  - Reset takes priority over a simultaneous handshake; the byte is not accepted.

## Timing
- After the first reset edge: `out` = 1, `ready` = 1, `busy` = 0, `done` = 0.
- Handshake at edge N: `out` = 0 and `busy` = 1 from cycle N+1. One cycle of input-to-line latency.
- Frame length is exactly 10·`Oversample` cycles:
  - start bit: cycles N+1 .. N+`Oversample`;
  - data bit k (k = 0 is the MSB): the following `Oversample`-cycle windows in order;
  - stop bit: cycles N+9·`Oversample`+1 .. N+10·`Oversample`.
- `done`/`ready` are high in cycle N+10·`Oversample`, the last stop-bit cycle.
- Back-to-back: a handshake in the last stop cycle makes `out` = 0 in the very next cycle. Frame period is exactly 10·`Oversample`, with no idle cycles.
- No handshake in the last stop cycle: next cycle is IDLE with `out` = 1 and `busy` = 0. A new handshake is possible in that IDLE cycle.
- `out` never glitches. It changes only at bit boundaries or on reset.

## Test plan
- Single byte, `Oversample`=16, `data`=0xA5:
  - line reads 0, then 1,0,1,0,0,1,0,1, then 1, each level for exactly 16 cycles;
  - `done` pulses once at cycle 160 after the handshake.
- Back-to-back, 0x00 then 0xFF with `valid` held high:
  - second start bit begins the cycle after the first `done`;
  - `ready` is high only in IDLE and in the last stop cycle.
- Reset asserted at cycle 50 of a 0x3C frame:
  - `out` = 1, `busy` = 0, `ready` = 1 on the next cycle;
  - no `done`;
  - a new 0x81 frame sent afterwards is bit-exact.
- `valid` pulsed while `busy`, with `data` changing mid-frame: ignored, and the frame in flight is unchanged.
- Loopback into the receiver (`Oversample` = 16 and 4), 256 random bytes sent back-to-back:
  - receiver `data` matches on every receiver `done`;
  - receiver `err` is never asserted.
- Idle line, `valid` = 0 for 1000 cycles: `out` stays 1, `done` stays 0, `busy` stays 0.

Source files
------------

// File: rtl/uart_tx_if.sv
// Upstream byte handshake into the UART transmitter.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    // The producer drives data/valid and watches ready.
    modport master (
        output data,
        output valid,
        input  ready
    );

    // The transmitter consumes data/valid and drives ready.
    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits MSB first, stop bit,
// each bit held for Oversample clocks; back-to-back frames without gaps.
module uart_tx #(
    parameter int unsigned Oversample = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  up,
    output logic      out,
    output logic      busy,
    output logic      done
);
    localparam int unsigned CntW = (Oversample > 1) ? $clog2(Oversample) : 1;
    localparam int unsigned BitW = 4;
    localparam logic [CntW-1:0] CntLast  = CntW'(Oversample - 1);
    localparam logic [BitW-1:0] BitFirst = BitW'(7);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [CntW-1:0] sample_count;
    logic [CntW-1:0] sample_count_next;
    logic [BitW-1:0] bit_count;
    logic [BitW-1:0] bit_count_next;
    logic [7:0]      shift_reg;
    logic [7:0]      shift_reg_next;
    logic            out_next;
    logic            busy_next;
    logic            done_next;
    logic            ready_next;
    logic            bit_last;
    logic            take;

    // Last cycle of the current bit, and an accepted byte this cycle.
    assign bit_last = (sample_count == '0);
    assign take     = up.valid && up.ready;

    // Next-state logic; outputs are derived from the next state so the
    // registered versions line up exactly with the state they describe.
    always_comb begin
        state_next        = state;
        sample_count_next = sample_count;
        bit_count_next    = bit_count;
        shift_reg_next    = shift_reg;
        out_next          = 1'b1;
        busy_next         = 1'b0;
        done_next         = 1'b0;
        ready_next        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (take) begin
                    shift_reg_next    = up.data;
                    sample_count_next = CntLast;
                    state_next        = ST_START;
                end
            end

            ST_START: begin
                if (bit_last) begin
                    state_next        = ST_DATA;
                    bit_count_next    = BitFirst;
                    sample_count_next = CntLast;
                end else begin
                    sample_count_next = sample_count - CntW'(1);
                end
            end

            ST_DATA: begin
                if (bit_last) begin
                    sample_count_next = CntLast;
                    if (bit_count == '0) begin
                        state_next = ST_STOP;
                    end else begin
                        shift_reg_next = {shift_reg[6:0], 1'b0};
                        bit_count_next = bit_count - BitW'(1);
                    end
                end else begin
                    sample_count_next = sample_count - CntW'(1);
                end
            end

            ST_STOP: begin
                if (bit_last) begin
                    sample_count_next = CntLast;
                    if (take) begin
                        // Back-to-back: next start bit follows immediately.
                        shift_reg_next = up.data;
                        state_next     = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    sample_count_next = sample_count - CntW'(1);
                end
            end

            default: begin
                state_next        = ST_IDLE;
                sample_count_next = CntLast;
            end
        endcase

        case (state_next)
            ST_START: out_next = 1'b0;
            ST_DATA:  out_next = shift_reg_next[7];
            default:  out_next = 1'b1;
        endcase

        busy_next  = (state_next != ST_IDLE);
        done_next  = (state_next == ST_STOP) && (sample_count_next == '0);
        ready_next = (state_next == ST_IDLE) || done_next;
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            sample_count <= CntLast;
            bit_count    <= BitFirst;
            shift_reg    <= '0;
            out          <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            up.ready     <= 1'b1;
        end else begin
            state        <= state_next;
            sample_count <= sample_count_next;
            bit_count    <= bit_count_next;
            shift_reg    <= shift_reg_next;
            out          <= out_next;
            busy         <= busy_next;
            done         <= done_next;
            up.ready     <= ready_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame timing, back-to-back, reset abort,
// ignored valid while busy, idle line, and loopback through a line decoder.
module tb_uart_tx;
    localparam int Os0      = 16;
    localparam int Os1      = 4;
    localparam int FrameLen = 10 * Os0;
    localparam int NBytes   = 256;

    logic clk;
    logic reset;
    logic out0, busy0, done0;
    logic out1, busy1, done1;

    uart_tx_if if0 ();
    uart_tx_if if1 ();

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] bytes [NBytes];

    uart_tx #(.Oversample(Os0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .up    (if0),
        .out   (out0),
        .busy  (busy0),
        .done  (done0)
    );

    uart_tx #(.Oversample(Os1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .up    (if1),
        .out   (out1),
        .busy  (busy1),
        .done  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic line_of(input int w);
        return (w == 0) ? out0 : out1;
    endfunction

    function automatic logic ready_of(input int w);
        return (w == 0) ? if0.ready : if1.ready;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : busy1;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? done0 : done1;
    endfunction

    task automatic set_up(input int w, input logic v, input logic [7:0] d);
        if (w == 0) begin
            if0.valid = v;
            if0.data  = d;
        end else begin
            if1.valid = v;
            if1.data  = d;
        end
    endtask

    // Present a byte on dut0 and return right after the accepting edge.
    task automatic start_frame(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        if0.data  = b;
        if0.valid = 1'b1;
        while (if0.ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (if0.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready: ready=%b after %0d cycles, required 1", if0.ready, guard);
        end
        @(posedge clk);
    endtask

    // Walk one dut0 frame cycle by cycle from the cycle after the handshake.
    // mode 0: drop valid; 1: hold valid with nb for a back-to-back frame;
    // 2: toggle valid and scramble data while busy.
    task automatic run_frame(input logic [7:0] b, input int mode, input logic [7:0] nb);
        logic exp_out;
        logic exp_last;
        int   k;
        for (int c = 1; c <= FrameLen; c++) begin
            @(negedge clk);
            if (c <= Os0) begin
                exp_out = 1'b0;
            end else if (c > 9 * Os0) begin
                exp_out = 1'b1;
            end else begin
                k = (c - Os0 - 1) / Os0;
                exp_out = b[3'(7 - k)];
            end
            exp_last = (c == FrameLen);

            n_cmp++;
            if (out0 !== exp_out) begin
                n_fail++;
                $display("FAIL frame_out byte=%h cycle=%0d: out=%b, required %b", b, c, out0, exp_out);
            end
            n_cmp++;
            if (done0 !== exp_last) begin
                n_fail++;
                $display("FAIL frame_done byte=%h cycle=%0d: done=%b, required %b", b, c, done0, exp_last);
            end
            n_cmp++;
            if (if0.ready !== exp_last) begin
                n_fail++;
                $display("FAIL frame_ready byte=%h cycle=%0d: ready=%b, required %b", b, c, if0.ready, exp_last);
            end
            n_cmp++;
            if (busy0 !== 1'b1) begin
                n_fail++;
                $display("FAIL frame_busy byte=%h cycle=%0d: busy=%b, required 1", b, c, busy0);
            end

            if (mode == 0 && c == 1) begin
                if0.valid = 1'b0;
            end else if (mode == 1 && c == 1) begin
                if0.data = nb;
            end else if (mode == 2) begin
                if (c < FrameLen) begin
                    if0.valid = 1'($urandom_range(0, 1));
                    if0.data  = 8'($urandom);
                end else begin
                    if0.valid = 1'b0;
                end
            end
        end

        if (mode != 1) begin
            @(negedge clk);
            n_cmp++;
            if (out0 !== 1'b1 || busy0 !== 1'b0 || if0.ready !== 1'b1 || done0 !== 1'b0) begin
                n_fail++;
                $display("FAIL after_frame byte=%h: out/busy/ready/done=%b%b%b%b, required 1010",
                         b, out0, busy0, if0.ready, done0);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out0 !== 1'b1) begin n_fail++; $display("FAIL reset_out: out=%b, required 1", out0); end
        n_cmp++;
        if (if0.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: ready=%b, required 1", if0.ready); end
        n_cmp++;
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy=%b, required 0", busy0); end
        n_cmp++;
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: done=%b, required 0", done0); end
        n_cmp++;
        if (out1 !== 1'b1 || if1.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_os4: out=%b ready=%b, required 1 1", out1, if1.ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_byte();
        start_frame(8'hA5);
        run_frame(8'hA5, 0, 8'h00);
    endtask

    task automatic test_back_to_back();
        start_frame(8'h00);
        run_frame(8'h00, 1, 8'hFF);
        run_frame(8'hFF, 0, 8'h00);
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'h3C);
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            if (c == 1) if0.valid = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out0 !== 1'b1 || busy0 !== 1'b0 || if0.ready !== 1'b1 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: out/busy/ready/done=%b%b%b%b, required 1010", out0, busy0, if0.ready, done0);
        end
        reset = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_cmp++;
            if (done0 !== 1'b0 || out0 !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_quiet cycle=%0d: done=%b out=%b, required 0 1", c, done0, out0);
            end
        end
        if0.data  = 8'h55;
        if0.valid = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        if0.valid = 1'b0;
        n_cmp++;
        if (busy0 !== 1'b0 || out0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_priority: busy=%b out=%b, required 0 1", busy0, out0);
        end
        start_frame(8'h81);
        run_frame(8'h81, 0, 8'h00);
    endtask

    task automatic test_ignore_valid_when_busy();
        start_frame(8'h5A);
        run_frame(8'h5A, 2, 8'h00);
    endtask

    task automatic test_idle_line();
        if0.valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL idle cycle=%0d: out/done/busy=%b%b%b, required 100", c, out0, done0, busy0);
            end
        end
    endtask

    // Producer side of the loopback: valid held high, next byte after each accept.
    task automatic send_stream(input int w);
        int i = 0;
        int guard = 0;
        logic hs;
        @(negedge clk);
        set_up(w, 1'b1, bytes[0]);
        hs = ready_of(w);
        while (i < NBytes && guard < 50000) begin
            @(negedge clk);
            guard++;
            if (hs) begin
                i++;
                if (i < NBytes) set_up(w, 1'b1, bytes[i]);
                else            set_up(w, 1'b0, 8'h00);
            end
            hs = (i < NBytes) && ready_of(w);
        end
        n_cmp++;
        if (i != NBytes) begin
            n_fail++;
            $display("FAIL stream_timeout dut=%0d: accepted %0d, required %0d", w, i, NBytes);
            set_up(w, 1'b0, 8'h00);
        end
    endtask

    // Receiver side: hunt for a start edge, sample each bit at its middle.
    task automatic rx_check(input int w, input int os);
        logic [7:0] got;
        logic       err;
        logic       ln;
        int         guard;
        for (int f = 0; f < NBytes; f++) begin
            guard = 0;
            do begin
                @(negedge clk);
                ln = line_of(w);
                guard++;
            end while (ln !== 1'b0 && guard < 20 * os);
            if (ln !== 1'b0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rx_timeout dut=%0d frame=%0d: no start bit", w, f);
                return;
            end
            repeat (os / 2) @(negedge clk);
            err = (line_of(w) !== 1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (os) @(negedge clk);
                got[3'(7 - k)] = line_of(w);
            end
            repeat (os) @(negedge clk);
            if (line_of(w) !== 1'b1) err = 1'b1;

            n_cmp++;
            if (got !== bytes[f]) begin
                n_fail++;
                $display("FAIL rx_data dut=%0d frame=%0d: got %h, required %h", w, f, got, bytes[f]);
            end
            n_cmp++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL rx_err dut=%0d frame=%0d: err=%b, required 0", w, f, err);
            end
        end
    endtask

    task automatic test_loopback(input int w, input int os);
        for (int i = 0; i < NBytes; i++) bytes[i] = 8'($urandom);
        fork
            send_stream(w);
            rx_check(w, os);
        join
        repeat (2 * os) @(negedge clk);
        n_cmp++;
        if (busy_of(w) !== 1'b0 || line_of(w) !== 1'b1 || done_of(w) !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_idle dut=%0d: busy/out/done=%b%b%b, required 010",
                     w, busy_of(w), line_of(w), done_of(w));
        end
    endtask

    initial begin
        reset     = 1'b1;
        if0.valid = 1'b0;
        if0.data  = 8'h00;
        if1.valid = 1'b0;
        if1.data  = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignore_valid_when_busy();
        test_idle_line();
        test_loopback(0, Os0);
        test_loopback(1, Os1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
